// File: rtl/fnd_pkg.sv
// Shared types, constants and the double-dabble step for the FND scan controller.
package fnd_pkg;

    // Converter FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } fsm_state_e;

    localparam int unsigned BCD_DIGITS  = 4;
    localparam int unsigned IN_W        = 14;
    localparam int unsigned MAX_VAL     = 9999;
    localparam int unsigned CONV_CYCLES = 14;
    localparam int unsigned BCD_W       = 4 * BCD_DIGITS;

    typedef logic [3:0] bcd_digit_t;

    // One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next bit.
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                                 input logic              bit_in);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int k = 0; k < int'(BCD_DIGITS); k++) begin
            if (adj[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
            end
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: clamps the input to 9999, then runs 14 double-dabble
// iterations. o_done pulses combinationally during the last iteration with o_bcd holding the
// final result, so the caller can capture all digits on the same edge the FSM returns to IDLE.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [IN_W-1:0]  i_bin,
    output logic             o_idle,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_ovf
);

    localparam int unsigned CNT_W = $clog2(CONV_CYCLES);

    fsm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] bcd_step;
    logic             ovf_q, ovf_d;
    logic             last_iter;

    // Next-state: accept and clamp in IDLE, one shift-add-3 iteration per CONV cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        bcd_step  = dd_step(bcd_q, bin_q[IN_W-1]);
        last_iter = (state_q == CONV) && (cnt_q == CNT_W'(CONV_CYCLES - 1));

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = CONV;
                    cnt_d   = '0;
                    bcd_d   = '0;
                    ovf_d   = (i_bin > IN_W'(MAX_VAL));
                    bin_d   = ovf_d ? IN_W'(MAX_VAL) : i_bin;
                end
            end
            CONV: begin
                bcd_d = bcd_step;
                bin_d = {bin_q[IN_W-2:0], 1'b0};
                if (last_iter) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; reset aborts any conversion in flight
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_idle = (state_q == IDLE);
    assign o_done = last_iter;
    assign o_bcd  = bcd_step;
    assign o_ovf  = ovf_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// FND scan controller: valid/ready intake, sequential BCD conversion, atomic display buffer
// and a free-running digit scan. Optional leading-zero blanking when FND_LZ_BLANK_EN is defined.
module fnd_scan_controller #(
    parameter int unsigned SCAN_DIV = 100_000,  // cycles per digit slot, >= 2
    parameter int unsigned IN_W     = 14        // fixed at 14
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    input  logic [IN_W-1:0] i_data,
    output logic            o_ready,
    output logic            o_ovf,
    output logic [1:0]      o_digit_sel,
    output logic [3:0]      o_value,
    output logic            o_en_n
);
    import fnd_pkg::*;

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic                               conv_idle;
    logic                               conv_done;
    logic [BCD_W-1:0]                   conv_bcd;
    logic                               start;

    bcd_digit_t [BCD_DIGITS-1:0]        buf_q, buf_d;
    logic [PRE_W-1:0]                   pre_q, pre_d;
    logic                               tick;
    logic [1:0]                         sel_q, sel_d;
    bcd_digit_t                         val_q, val_d;
    logic                               en_n_q, en_n_d;

    assign start = i_valid && conv_idle;

    bin2bcd_seq u_conv (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (start),
        .i_bin   (i_data),
        .o_idle  (conv_idle),
        .o_done  (conv_done),
        .o_bcd   (conv_bcd),
        .o_ovf   (o_ovf)
    );

    // Buffer takes all four digits at once when the conversion finishes
    always_comb begin
        buf_d = buf_q;
        if (conv_done) begin
            buf_d = conv_bcd;
        end
    end

    // Prescaler and slot counter; independent of the converter so CONV never stalls the scan
    always_comb begin
        tick  = (pre_q == PRE_W'(SCAN_DIV - 1));
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        sel_d = tick ? sel_q + 2'd1 : sel_q;
        val_d = buf_q[sel_d];
    end

`ifdef FND_LZ_BLANK_EN
    // Blank slot k>=1 when it and every higher digit are zero; slot 0 always lit
    always_comb begin
        en_n_d = (sel_d != 2'd0);
        for (int k = 0; k < int'(BCD_DIGITS); k++) begin
            if ((k >= int'(sel_d)) && (buf_q[k] != 4'd0)) begin
                en_n_d = 1'b0;
            end
        end
    end
`else
    // Every slot lit; leading zeros are shown
    always_comb begin
        en_n_d = 1'b0;
    end
`endif

    // Display and scan registers; outputs change together on the slot edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            buf_q  <= '0;
            pre_q  <= '0;
            sel_q  <= 2'd0;
            val_q  <= 4'd0;
            en_n_q <= 1'b1;
        end else begin
            buf_q  <= buf_d;
            pre_q  <= pre_d;
            sel_q  <= sel_d;
            val_q  <= val_d;
            en_n_q <= en_n_d;
        end
    end

    assign o_ready     = conv_idle;
    assign o_digit_sel = sel_q;
    assign o_value     = val_q;
    assign o_en_n      = en_n_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with SCAN_DIV=4. Accepted values are queued with
// their expected display/overflow and popped when the DUT finishes the conversion.
module tb_fnd_scan_controller;

    logic        clk;
    logic        i_reset;
    logic        i_valid;
    logic [13:0] i_data;
    logic        o_ready;
    logic        o_ovf;
    logic [1:0]  o_digit_sel;
    logic [3:0]  o_value;
    logic        o_en_n;

    typedef struct {
        int val;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   disp_val = 0;

    fnd_scan_controller #(
        .SCAN_DIV (4),
        .IN_W     (14)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_ovf       (o_ovf),
        .o_digit_sel (o_digit_sel),
        .o_value     (o_value),
        .o_en_n      (o_en_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dig(input int v, input int k);
        int d = v;
        for (int i = 0; i < k; i++) d = d / 10;
        return d % 10;
    endfunction

    function automatic int exp_en_n(input int v, input int k);
`ifdef FND_LZ_BLANK_EN
        int p = 1;
        if (k == 0) return 0;
        for (int i = 0; i < k; i++) p = p * 10;
        return (v / p == 0) ? 1 : 0;
`else
        return 0 * v * k;
`endif
    endfunction

    // Visit slots 0..3 in order and compare against the bench's display value
    task automatic check_display(input int ovf);
        int n;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (o_digit_sel !== 2'(k) && n < 20) begin
                step();
                n++;
            end
            chk($sformatf("slot%0d_reached", k), (n < 20) ? 1 : 0, 1);
            chk($sformatf("value_slot%0d", k), o_value, dig(disp_val, k));
            chk($sformatf("en_n_slot%0d", k), o_en_n, exp_en_n(disp_val, k));
        end
        chk("ovf", o_ovf, ovf);
    endtask

    // Accept v; optionally present ign_val with i_valid during CONV cycle ign_at
    task automatic accept(input int v, input int ign_at, input int ign_val);
        exp_t e;
        int   n;
        e.val = (v > 9999) ? 9999 : v;
        e.ovf = (v > 9999) ? 1 : 0;
        sb.push_back(e);
        chk("ready_before_accept", o_ready, 1);
        i_valid = 1'b1;
        i_data  = 14'(v);
        step();
        i_valid = 1'b0;
        chk("busy_after_accept", o_ready, 0);
        n = 0;
        while (o_ready !== 1'b1 && n < 40) begin
            if (n + 1 == ign_at) begin
                i_valid = 1'b1;
                i_data  = 14'(ign_val);
            end else begin
                i_valid = 1'b0;
            end
            step();
            n++;
        end
        i_valid = 1'b0;
        chk("busy_len", n, 14);
        // Buffer has just been written; the registered o_value still reflects the old buffer
        chk("value_before_update", o_value, dig(disp_val, int'(o_digit_sel)));
        e = sb.pop_front();
        disp_val = e.val;
        step();
        chk("value_at_latency", o_value, dig(disp_val, int'(o_digit_sel)));
        check_display(e.ovf);
    endtask

    initial begin
        int s0;
        int n;
        int prev;
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;

        repeat (3) step();
        chk("rst_ready", o_ready, 1);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_sel", o_digit_sel, 0);
        chk("rst_value", o_value, 0);
        chk("rst_en_n", o_en_n, 1);
        i_reset = 1'b0;
        step();
        disp_val = 0;
        check_display(0);

        accept(1234, 0, 0);
        accept(12000, 0, 0);
        accept(42, 0, 0);
        accept(5678, 3, 1111);
        chk("no_late_accept", o_ready, 1);

        // Free-run: slot steps every 4 cycles and o_value tracks the buffer
        prev = int'(o_digit_sel);
        n = 0;
        while (int'(o_digit_sel) == prev && n < 8) begin
            step();
            n++;
        end
        chk("scan_moving", (n < 8) ? 1 : 0, 1);
        s0 = int'(o_digit_sel);
        for (int j = 1; j <= 20; j++) begin
            step();
            chk($sformatf("scan_sel_j%0d", j), o_digit_sel, (s0 + j / 4) % 4);
            chk($sformatf("scan_val_j%0d", j), o_value, dig(disp_val, (s0 + j / 4) % 4));
        end

        accept(7, 0, 0);

        // Reset in CONV cycle 5 of 8888 aborts the conversion
        i_valid = 1'b1;
        i_data  = 14'(8888);
        step();
        i_valid = 1'b0;
        repeat (4) step();
        chk("abort_busy", o_ready, 0);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        chk("abort_ready", o_ready, 1);
        chk("abort_ovf", o_ovf, 0);
        chk("abort_sel", o_digit_sel, 0);
        chk("abort_value", o_value, 0);
        disp_val = 0;
        for (int j = 0; j < 24; j++) begin
            step();
            chk("abort_no_8888", o_value, 0);
        end
        chk("abort_idle", o_ready, 1);
        check_display(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
